// File: rtl/nrx_hvgen.sv
// nrx_hvgen: New Rally-X video timing generator.
// A free-running /4 prescaler produces the pixel enable. The H/V raster
// counters, blank/sync flags, the per-frame CPU interrupt, the interrupt-enable
// latch (memory A181h) and the IM2 vector register (I/O port 00h) all live here.
//
// Interface notes:
//  - Every output is a flop. No CPU input reaches an output combinationally.
//  - The counters and PCE move together on the edge where the prescaler
//    reads 3. PCE is therefore high during the cycle in which HPOS/VPOS show
//    their new value.
//  - The flags are computed from the next counter values. They change on the
//    same edge as HPOS/VPOS, so there is no skew between flags and position.
module nrx_hvgen #(
    parameter int unsigned H_TOTAL  = 384,
    parameter int unsigned H_ACTIVE = 288,
    parameter int unsigned HS_START = 304,
    parameter int unsigned HS_WIDTH = 32,
    parameter int unsigned V_TOTAL  = 264,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned VS_START = 232,
    parameter int unsigned VS_WIDTH = 8
) (
    input  logic        VCLKx4,
    input  logic        RESET,
    output logic        PCE,
    output logic [8:0]  HPOS,
    output logic [8:0]  VPOS,
    output logic        HBLANK,
    output logic        VBLANK,
    output logic        HSYNC,
    output logic        VSYNC,
    input  logic [15:0] CPUADDR,
    input  logic [7:0]  CPUDI,
    input  logic        CPUMWR,
    input  logic        CPUIOWR,
    input  logic        CPUIACK,
    output logic        IRQ,
    output logic [7:0]  IRQVEC
);

    localparam logic [8:0]  H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0]  V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0]  HS_BEGIN = 9'(HS_START);
    localparam logic [8:0]  HS_END   = 9'(HS_START + HS_WIDTH);
    localparam logic [8:0]  VS_BEGIN = 9'(VS_START);
    localparam logic [8:0]  VS_END   = 9'(VS_START + VS_WIDTH);
    localparam logic [15:0] IRQEN_ADDR = 16'hA181;

    logic [1:0] presc;
    logic       tick;
    logic [8:0] hpos_nxt;
    logic [8:0] vpos_nxt;
    logic       irqen;
    logic       irqen_wr;
    logic       vec_wr;
    logic       irq_set;
    logic       irq_clr;

    // The pixel step happens on the edge where the prescaler reads 3.
    assign tick = (presc == 2'd3);

    // CPU register decodes. The enable latch decodes the full 16-bit address.
    // The vector port decodes only the low byte, which is the Z80 I/O port number.
    assign irqen_wr = CPUMWR && (CPUADDR == IRQEN_ADDR);
    assign vec_wr   = CPUIOWR && (CPUADDR[7:0] == 8'h00);

    // An interrupt is raised when the raster steps onto the first pixel of the
    // first blanked line. The enable used here is the latched value from before
    // any write in the same cycle.
    assign irq_set = tick && (hpos_nxt == 9'd0) && (vpos_nxt == V_ACT) && irqen;
    assign irq_clr = CPUIACK || (irqen_wr && !CPUDI[0]);

    // Next raster position. It holds between pixel enables.
    always_comb begin
        hpos_nxt = HPOS;
        vpos_nxt = VPOS;
        if (tick) begin
            if (HPOS == H_LAST) begin
                hpos_nxt = 9'd0;
                vpos_nxt = (VPOS == V_LAST) ? 9'd0 : VPOS + 9'd1;
            end else begin
                hpos_nxt = HPOS + 9'd1;
            end
        end
    end

    // Prescaler and pixel-enable register.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            presc <= 2'd0;
            PCE   <= 1'b0;
        end else begin
            presc <= presc + 2'd1;
            PCE   <= tick;
        end
    end

    // Raster counters, and flags derived from the position they are moving to.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            HPOS   <= 9'd0;
            VPOS   <= 9'd0;
            HBLANK <= 1'b0;
            VBLANK <= 1'b0;
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
        end else begin
            HPOS   <= hpos_nxt;
            VPOS   <= vpos_nxt;
            HBLANK <= (hpos_nxt >= H_ACT);
            VBLANK <= (vpos_nxt >= V_ACT);
            HSYNC  <= (hpos_nxt >= HS_BEGIN) && (hpos_nxt < HS_END);
            VSYNC  <= (vpos_nxt >= VS_BEGIN) && (vpos_nxt < VS_END);
        end
    end

    // CPU-visible registers: enable latch and IM2 vector.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            irqen  <= 1'b0;
            IRQVEC <= 8'h00;
        end else begin
            if (irqen_wr) begin
                irqen <= CPUDI[0];
            end
            if (vec_wr) begin
                IRQVEC <= CPUDI;
            end
        end
    end

    // Interrupt request is a level that holds until it is cleared.
    // Clear beats set when both happen in the same cycle.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            IRQ <= 1'b0;
        end else if (irq_clr) begin
            IRQ <= 1'b0;
        end else if (irq_set) begin
            IRQ <= 1'b1;
        end
    end

endmodule
